// File: rtl/iob_pcie_tx_engine.sv
// RIFFA-style PCIe channel transmit engine.
// CPU words are packed LSB-first into PCI_DATA_W beats, buffered in a
// first-word-fall-through FIFO and streamed to the host under the
// tx/ack/valid/ren handshake. A no-progress timeout aborts the transaction.
module iob_pcie_tx_engine #(
    parameter int PCI_DATA_W  = 64,
    parameter int FIFO_ADDR_W = 5,
    parameter int TIMEOUT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [31:0]           len_i,
    input  logic [30:0]           off_i,
    input  logic                  last_i,
    input  logic [TIMEOUT_W-1:0]  timeout_i,
    input  logic [31:0]           wdata_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [FIFO_ADDR_W:0]  level_o,
    output logic                  chnl_tx_o,
    output logic                  chnl_tx_last_o,
    output logic [31:0]           chnl_tx_len_o,
    output logic [30:0]           chnl_tx_off_o,
    output logic [PCI_DATA_W-1:0] chnl_tx_data_o,
    output logic                  chnl_tx_data_valid_o,
    input  logic                  chnl_tx_data_ren_i,
    input  logic                  chnl_tx_ack_i
);

    localparam int R     = PCI_DATA_W / 32;
    localparam int SHIFT = $clog2(R);
    localparam int CNT_W = (R > 1) ? SHIFT : 1;
    localparam int DEPTH = 1 << FIFO_ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_STREAM,
        S_DONE,
        S_ERR
    } state_t;

    state_t                  state_q, state_d;

    logic [31:0]             len_q;
    logic [30:0]             off_q;
    logic                    last_q;
    logic [31:0]             beats_left_q;
    logic [31:0]             words_q;

    logic [PCI_DATA_W-1:0]   pk_buf_q;
    logic [PCI_DATA_W-1:0]   pk_merged;
    logic [CNT_W-1:0]        pk_cnt_q;

    logic [FIFO_ADDR_W:0]    wr_ptr_q, rd_ptr_q;
    logic [FIFO_ADDR_W:0]    fifo_level;
    logic [PCI_DATA_W-1:0]   mem_q [DEPTH];
    logic [PCI_DATA_W-1:0]   fifo_head;

    logic [TIMEOUT_W-1:0]    tmo_cnt_q, tmo_cnt_d, tmo_next;
    logic                    err_q, err_d;
    logic                    zdone_q;

    logic                    start_go, start_zero;
    logic                    active, flush;
    logic                    fifo_empty, fifo_full;
    logic                    would_push, wr_acc, push, pop;
    logic                    progress, tmo_hit;
    logic [32:0]             len_round;
    logic [31:0]             beats_init;

    // Transaction launch decode and beat count ceil(len/R) without 32-bit wrap.
    assign start_go   = (state_q == S_IDLE) && start_i && (len_i != 32'd0);
    assign start_zero = (state_q == S_IDLE) && start_i && (len_i == 32'd0);
    assign len_round  = {1'b0, len_i} + 33'(R - 1);
    assign beats_init = 32'(len_round >> SHIFT);

    assign active = (state_q == S_REQ) || (state_q == S_STREAM);
    assign flush  = (state_q == S_ERR);

    // FIFO status; the head is shown only while valid so idle/reset data reads 0.
    assign fifo_level = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = (fifo_level == (FIFO_ADDR_W + 1)'(DEPTH));
    assign fifo_head  = mem_q[rd_ptr_q[FIFO_ADDR_W-1:0]];

    // A word is refused only when it would close a beat into a full FIFO.
    assign would_push = (pk_cnt_q == CNT_W'(R - 1)) || (words_q == len_q - 32'd1);
    assign wready_o   = active && (words_q < len_q) && !(would_push && fifo_full);
    assign wr_acc     = wvalid_i && wready_o;
    assign push       = wr_acc && would_push;
    assign pop        = (state_q == S_STREAM) && !fifo_empty && chnl_tx_data_ren_i;

    // Insert the incoming word into its lane; lanes above it are still zero.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        pk_merged = pk_buf_q;
        for (int k = 0; k < R; k++) begin
            if (pk_cnt_q == CNT_W'(k)) begin
                pk_merged[32*k +: 32] = wdata_i;
            end
        end
    end

    // No-progress watchdog: ack or pop restarts it, a zero limit disables it.
    always_comb begin
        progress  = chnl_tx_ack_i || pop;
        tmo_next  = tmo_cnt_q + TIMEOUT_W'(1);
        tmo_hit   = active && (timeout_i != '0) && !progress && (tmo_next == timeout_i);
        tmo_cnt_d = (active && (timeout_i != '0) && !progress) ? tmo_next : '0;
    end

    // Next-state logic and sticky error flag.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        if (start_go || start_zero) begin
            err_d = 1'b0;
        end
        if (tmo_hit) begin
            err_d = 1'b1;
        end
        case (state_q)
            S_IDLE:   if (start_go) state_d = S_REQ;
            S_REQ: begin
                if (tmo_hit)            state_d = S_ERR;
                else if (chnl_tx_ack_i) state_d = S_STREAM;
            end
            S_STREAM: begin
                if (tmo_hit)                             state_d = S_ERR;
                else if (pop && (beats_left_q == 32'd1)) state_d = S_DONE;
            end
            S_DONE:   state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM state, watchdog, status flags and latched transaction attributes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            tmo_cnt_q    <= '0;
            err_q        <= 1'b0;
            zdone_q      <= 1'b0;
            len_q        <= '0;
            off_q        <= '0;
            last_q       <= 1'b0;
            beats_left_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
            zdone_q   <= start_zero;
            if (start_go) begin
                len_q        <= len_i;
                off_q        <= off_i;
                last_q       <= last_i;
                beats_left_q <= beats_init;
            end else if (pop) begin
                beats_left_q <= beats_left_q - 32'd1;
            end
        end
    end

    // Word counter and beat packer; cleared at launch and on abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_q  <= '0;
            pk_buf_q <= '0;
            pk_cnt_q <= '0;
        end else if (start_go || flush) begin
            words_q  <= '0;
            pk_buf_q <= '0;
            pk_cnt_q <= '0;
        end else if (wr_acc) begin
            words_q <= words_q + 32'd1;
            if (would_push) begin
                pk_buf_q <= '0;
                pk_cnt_q <= '0;
            end else begin
                pk_buf_q <= pk_merged;
                pk_cnt_q <= pk_cnt_q + CNT_W'(1);
            end
        end
    end

    // FIFO pointers; an abort empties the FIFO by rewinding both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Beat storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers define validity and the output is masked while empty.
        if (push) begin
            mem_q[wr_ptr_q[FIFO_ADDR_W-1:0]] <= pk_merged;
        end
    end

    assign busy_o               = active || (state_q == S_DONE);
    assign done_o               = (state_q == S_DONE) || zdone_q;
    assign err_o                = err_q;
    assign level_o              = fifo_level;
    assign chnl_tx_o            = active;
    assign chnl_tx_last_o       = last_q;
    assign chnl_tx_len_o        = len_q;
    assign chnl_tx_off_o        = off_q;
    assign chnl_tx_data_valid_o = (state_q == S_STREAM) && !fifo_empty;
    assign chnl_tx_data_o       = chnl_tx_data_valid_o ? fifo_head : '0;

endmodule

// File: tb/tb_iob_pcie_tx_engine.sv
// Directed bench for iob_pcie_tx_engine: a 64-bit instance with a 4-beat FIFO
// and a 128-bit instance, expected beats built from the word patterns fed in.
module tb_iob_pcie_tx_engine;

    logic clk;
    logic rst_n;

    // 64-bit, 4-beat FIFO instance
    logic        a_start, a_last, a_wvalid, a_wready, a_busy, a_done, a_err;
    logic [31:0] a_len, a_wdata, a_tx_len;
    logic [30:0] a_off, a_tx_off;
    logic [15:0] a_timeout;
    logic [2:0]  a_level;
    logic        a_tx, a_tx_last, a_valid, a_ren, a_ack;
    logic [63:0] a_data;

    // 128-bit, 4-beat FIFO instance
    logic         b_start, b_last, b_wvalid, b_wready, b_busy, b_done, b_err;
    logic [31:0]  b_len, b_wdata, b_tx_len;
    logic [30:0]  b_off, b_tx_off;
    logic [15:0]  b_timeout;
    logic [2:0]   b_level;
    logic         b_tx, b_tx_last, b_valid, b_ren, b_ack;
    logic [127:0] b_data;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    logic [63:0]  a_q[$];
    logic [127:0] b_q[$];
    int   a_done_cnt = 0;
    int   b_done_cnt = 0;
    int   a_done_cyc = 0;
    int   a_pop_cyc  = 0;
    int   a_fed      = 0;
    logic a_done_tx   = 1'b0;
    logic a_done_busy = 1'b0;

    iob_pcie_tx_engine #(.PCI_DATA_W(64), .FIFO_ADDR_W(2), .TIMEOUT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(a_start), .len_i(a_len), .off_i(a_off),
        .last_i(a_last), .timeout_i(a_timeout), .wdata_i(a_wdata), .wvalid_i(a_wvalid),
        .wready_o(a_wready), .busy_o(a_busy), .done_o(a_done), .err_o(a_err),
        .level_o(a_level), .chnl_tx_o(a_tx), .chnl_tx_last_o(a_tx_last),
        .chnl_tx_len_o(a_tx_len), .chnl_tx_off_o(a_tx_off), .chnl_tx_data_o(a_data),
        .chnl_tx_data_valid_o(a_valid), .chnl_tx_data_ren_i(a_ren), .chnl_tx_ack_i(a_ack)
    );

    iob_pcie_tx_engine #(.PCI_DATA_W(128), .FIFO_ADDR_W(2), .TIMEOUT_W(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(b_start), .len_i(b_len), .off_i(b_off),
        .last_i(b_last), .timeout_i(b_timeout), .wdata_i(b_wdata), .wvalid_i(b_wvalid),
        .wready_o(b_wready), .busy_o(b_busy), .done_o(b_done), .err_o(b_err),
        .level_o(b_level), .chnl_tx_o(b_tx), .chnl_tx_last_o(b_tx_last),
        .chnl_tx_len_o(b_tx_len), .chnl_tx_off_o(b_tx_off), .chnl_tx_data_o(b_data),
        .chnl_tx_data_valid_o(b_valid), .chnl_tx_data_ren_i(b_ren), .chnl_tx_ack_i(b_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Host-side monitor: beats popped and done pulses, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (a_valid && a_ren) begin
            a_q.push_back(a_data);
            a_pop_cyc = cyc;
        end
        if (a_done) begin
            a_done_cnt++;
            a_done_cyc  = cyc;
            a_done_tx   = a_tx;
            a_done_busy = a_busy;
        end
        if (b_valid && b_ren) b_q.push_back(b_data);
        if (b_done) b_done_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wd(input logic [31:0] base, input int i);
        return base + 32'(i);
    endfunction

    task automatic a_begin(input logic [31:0] len, input logic [30:0] off, input logic last);
        a_start = 1'b1;
        a_len   = len;
        a_off   = off;
        a_last  = last;
        @(posedge clk);
        #1;
        a_start = 1'b0;
    endtask

    task automatic b_begin(input logic [31:0] len, input logic [30:0] off, input logic last);
        b_start = 1'b1;
        b_len   = len;
        b_off   = off;
        b_last  = last;
        @(posedge clk);
        #1;
        b_start = 1'b0;
    endtask

    task automatic a_feed(input logic [31:0] base, input int n);
        int   i;
        int   g;
        logic acc;
        i = 0;
        g = 0;
        a_fed    = 0;
        a_wvalid = 1'b1;
        a_wdata  = base;
        while (i < n && g < 2000) begin
            @(negedge clk);
            acc = a_wready;
            @(posedge clk);
            #1;
            g++;
            if (acc) begin
                i++;
                a_wdata = wd(base, i);
            end
            a_fed = i;
        end
        a_wvalid = 1'b0;
        check("a_feed_words", 128'(i), 128'(n));
    endtask

    task automatic b_feed(input logic [31:0] base, input int n);
        int   i;
        int   g;
        logic acc;
        i = 0;
        g = 0;
        b_wvalid = 1'b1;
        b_wdata  = base;
        while (i < n && g < 2000) begin
            @(negedge clk);
            acc = b_wready;
            @(posedge clk);
            #1;
            g++;
            if (acc) begin
                i++;
                b_wdata = wd(base, i);
            end
        end
        b_wvalid = 1'b0;
        check("b_feed_words", 128'(i), 128'(n));
    endtask

    task automatic a_ack_after(input int n);
        repeat (n) @(posedge clk);
        #1;
        a_ack = 1'b1;
        @(posedge clk);
        #1;
        a_ack = 1'b0;
    endtask

    task automatic b_ack_after(input int n);
        repeat (n) @(posedge clk);
        #1;
        b_ack = 1'b1;
        @(posedge clk);
        #1;
        b_ack = 1'b0;
    endtask

    task automatic a_wait_done(input string tag, input int base);
        int g;
        g = 0;
        while (a_done_cnt == base && g < 400) begin
            @(posedge clk);
            #1;
            g++;
        end
        check(tag, 128'(g < 400), 128'd1);
    endtask

    task automatic b_wait_done(input string tag, input int base);
        int g;
        g = 0;
        while (b_done_cnt == base && g < 400) begin
            @(posedge clk);
            #1;
            g++;
        end
        check(tag, 128'(g < 400), 128'd1);
    endtask

    initial begin
        int qb;
        int db;
        int hi;
        logic [31:0] base;

        rst_n = 1'b0;
        {a_start, a_last, a_wvalid, a_ren, a_ack} = '0;
        {b_start, b_last, b_wvalid, b_ren, b_ack} = '0;
        a_len = '0; a_off = '0; a_timeout = '0; a_wdata = '0;
        b_len = '0; b_off = '0; b_timeout = '0; b_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state of both instances
        check("rst_a_flags", 128'({a_busy, a_done, a_err, a_tx, a_tx_last, a_valid, a_wready}), 128'd0);
        check("rst_a_level", 128'(a_level), 128'd0);
        check("rst_a_data", 128'(a_data), 128'd0);
        check("rst_a_lenoff", 128'({a_tx_len, a_tx_off}), 128'd0);
        check("rst_b_flags", 128'({b_busy, b_done, b_err, b_tx, b_tx_last, b_valid, b_wready}), 128'd0);
        check("rst_b_misc", 128'({b_level, b_data, b_tx_len, b_tx_off}), 128'd0);
        @(posedge clk);
        #1;

        // 1: len=4, ack after 3 cycles, two full beats
        base  = 32'h1111_0000;
        a_ren = 1'b1;
        qb    = a_q.size();
        db    = a_done_cnt;
        a_begin(32'd4, 31'd0, 1'b1);
        check("t1_req", 128'({a_tx, a_busy}), 128'b11);
        check("t1_attr", 128'({a_tx_last, a_tx_len, a_tx_off}), 128'({1'b1, 32'd4, 31'd0}));
        fork
            a_feed(base, 4);
            a_ack_after(3);
        join
        a_wait_done("t1_done_seen", db);
        check("t1_nbeats", 128'(a_q.size() - qb), 128'd2);
        check("t1_beat0", 128'(a_q[qb]), 128'({wd(base, 1), wd(base, 0)}));
        check("t1_beat1", 128'(a_q[qb+1]), 128'({wd(base, 3), wd(base, 2)}));
        check("t1_done_lat", 128'(a_done_cyc - a_pop_cyc), 128'd1);
        check("t1_done_tx_busy", 128'({a_done_tx, a_done_busy}), 128'b01);
        repeat (2) @(posedge clk);
        #1;
        check("t1_done_pulses", 128'(a_done_cnt - db), 128'd1);
        check("t1_idle", 128'({a_busy, a_tx, a_level}), 128'd0);

        // 2: len=3, partial final beat zero-filled
        base = 32'h2222_0000;
        qb   = a_q.size();
        db   = a_done_cnt;
        a_begin(32'd3, 31'd5, 1'b1);
        fork
            a_feed(base, 3);
            a_ack_after(1);
        join
        a_wait_done("t2_done_seen", db);
        repeat (2) @(posedge clk);
        #1;
        check("t2_nbeats", 128'(a_q.size() - qb), 128'd2);
        check("t2_beat0", 128'(a_q[qb]), 128'({wd(base, 1), wd(base, 0)}));
        check("t2_beat1", 128'(a_q[qb+1]), 128'({32'h0, wd(base, 2)}));
        check("t2_level", 128'(a_level), 128'd0);

        // 3: len=20 into a 4-beat FIFO with the host stalled
        base  = 32'h3333_0000;
        a_ren = 1'b0;
        qb    = a_q.size();
        db    = a_done_cnt;
        a_begin(32'd20, 31'd0, 1'b0);
        fork
            a_feed(base, 20);
            begin
                a_ack_after(1);
                repeat (30) @(posedge clk);
                @(negedge clk);
                check("t3_full_level", 128'(a_level), 128'd4);
                check("t3_words_held", 128'(a_fed), 128'd9);
                check("t3_wready", 128'({a_wready, a_valid}), 128'b01);
                check("t3_head", 128'(a_data), 128'({wd(base, 1), wd(base, 0)}));
                @(posedge clk);
                #1;
                a_ren = 1'b1;
            end
        join
        a_wait_done("t3_done_seen", db);
        check("t3_nbeats", 128'(a_q.size() - qb), 128'd10);
        for (int j = 0; j < 10; j++) begin
            check($sformatf("t3_beat%0d", j), 128'(a_q[qb+j]),
                  128'({wd(base, 2*j+1), wd(base, 2*j)}));
        end

        // 4: timeout=8 with no ack; one beat buffered then flushed
        base      = 32'h4444_0000;
        a_timeout = 16'd8;
        db        = a_done_cnt;
        hi        = 0;
        a_begin(32'd2, 31'd0, 1'b0);
        a_wvalid = 1'b1;
        a_wdata  = wd(base, 0);
        @(negedge clk);
        if (a_tx && !a_err) hi++;
        @(posedge clk);
        #1;
        a_wdata = wd(base, 1);
        @(negedge clk);
        if (a_tx && !a_err) hi++;
        @(posedge clk);
        #1;
        a_wvalid = 1'b0;
        @(negedge clk);
        if (a_tx && !a_err) hi++;
        check("t4_level_buf", 128'(a_level), 128'd1);
        repeat (5) begin
            @(negedge clk);
            if (a_tx && !a_err) hi++;
        end
        check("t4_req_cycles", 128'(hi), 128'd8);
        @(negedge clk);
        check("t4_err_state", 128'({a_err, a_tx, a_busy, a_valid}), 128'b1000);
        @(negedge clk);
        check("t4_flushed", 128'({a_level, a_err, a_busy}), 128'({3'd0, 1'b1, 1'b0}));
        check("t4_no_done", 128'(a_done_cnt - db), 128'd0);
        @(posedge clk);
        #1;
        a_timeout = 16'd0;
        a_begin(32'd0, 31'd0, 1'b0);
        @(negedge clk);
        check("t4_zero_len", 128'({a_err, a_done, a_tx, a_busy}), 128'b0100);
        @(posedge clk);
        #1;

        // 5: 128-bit beats, len=5, off=7, last=0
        base  = 32'h5555_0000;
        b_ren = 1'b1;
        qb    = b_q.size();
        db    = b_done_cnt;
        b_begin(32'd5, 31'd7, 1'b0);
        check("t5_attr", 128'({b_tx, b_tx_last, b_tx_len, b_tx_off}), 128'({1'b1, 1'b0, 32'd5, 31'd7}));
        fork
            b_feed(base, 5);
            b_ack_after(1);
        join
        b_wait_done("t5_done_seen", db);
        repeat (2) @(posedge clk);
        #1;
        check("t5_nbeats", 128'(b_q.size() - qb), 128'd2);
        check("t5_beat0", b_q[qb], {wd(base, 3), wd(base, 2), wd(base, 1), wd(base, 0)});
        check("t5_beat1", b_q[qb+1], {96'h0, wd(base, 4)});
        check("t5_idle", 128'({b_busy, b_err, b_level}), 128'd0);

        // 6: asynchronous reset in the middle of a stream, then a clean transfer
        base  = 32'h6666_0000;
        a_ren = 1'b0;
        a_begin(32'd8, 31'd3, 1'b1);
        fork
            a_feed(base, 4);
            a_ack_after(1);
        join
        @(negedge clk);
        check("t6_pre_reset", 128'({a_level, a_tx, a_valid}), 128'({3'd2, 1'b1, 1'b1}));
        rst_n = 1'b0;
        #1;
        check("t6_rst_flags", 128'({a_busy, a_done, a_err, a_tx, a_tx_last, a_valid, a_wready}), 128'd0);
        check("t6_rst_level_data", 128'({a_level, a_data}), 128'd0);
        check("t6_rst_attr", 128'({a_tx_len, a_tx_off}), 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        a_ren = 1'b1;
        @(posedge clk);
        #1;
        base = 32'h6767_0000;
        qb   = a_q.size();
        db   = a_done_cnt;
        a_begin(32'd2, 31'd0, 1'b1);
        fork
            a_feed(base, 2);
            a_ack_after(1);
        join
        a_wait_done("t6_done_seen", db);
        repeat (2) @(posedge clk);
        #1;
        check("t6_nbeats", 128'(a_q.size() - qb), 128'd1);
        check("t6_beat0", 128'(a_q[qb]), 128'({wd(base, 1), wd(base, 0)}));
        check("t6_idle", 128'({a_busy, a_level, a_err}), 128'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
